fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Sequences and shares the single-port LCD framebuffer RAM in the CLK_SYS (200 MHz) domain. It has two requesters: the scan-out prefetcher that feeds the pixel-clock timing generator, and the host writer that updates DSKY display content. After reset it clears the whole framebuffer to zero before granting anyone. It then arbitrates with scan priority plus a bounded-starvation guarantee for the host, and routes read data back to the requester that issued it.

## Interface
- ADDR_W, 17, framebuffer address width
- DATA_W, 16, pixel word width (RGB565)
- DEPTH, 2**ADDR_W, number of words cleared at init (≤ 2**ADDR_W)
- RD_LAT, 2, RAM read latency in cycles from mem_en to mem_rdata valid (≥1)
- MAX_WAIT, 8, consecutive host-losing cycles before host boost (≥1)

Ports:
- CLK_SYS  in  1  system clock
- Reset_Button  in  1  reset, asynchronous, active-low
- scan_req  in  1  scan read request, held with scan_addr until scan_gnt
- scan_addr  in  ADDR_W  scan read address
- scan_urgent  in  1  scan FIFO below low-water mark; overrides host boost
- scan_gnt  out  1  scan handshake accepted this cycle
- scan_rvalid  out  1  scan read data valid
- scan_rdata  out  DATA_W  scan read data
- host_req  in  1  host request, held with host_we/addr/wdata until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host handshake accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_en, mem_we  out  1  RAM command strobe / write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- init_done  out  1  high once clear sequence finished

## Operation
- FSM states: CLEAR, NORMAL, BOOST.
- CLEAR (entered on reset):
  - Issue one write per cycle, addr 0..DEPTH-1, data 0.
  - No grants.
  - After the write to DEPTH-1, go to NORMAL; init_done rises the same cycle and stays high until the next reset.
- NORMAL:
  - scan_req → scan_gnt.
  - Else host_req → host_gnt.
  - At most one grant per cycle.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - Increments each cycle host_req && !host_gnt.
  - Saturates at MAX_WAIT.
  - Clears on host_gnt or when !host_req.
- Reaching MAX_WAIT in NORMAL → BOOST next cycle.
- BOOST:
  - host_req has priority over scan_req unless scan_urgent=1 (then scan wins).
  - On host_gnt → NORMAL, wait_cnt=0.
  - If host_req drops → NORMAL.
- Grants are combinational from current req/state. Requests may not be withdrawn before their grant.
- Each granted read pushes a tag (SCAN/HOST) into a tag pipeline. The matching rvalid pulses with rdata = mem_rdata. Writes push tag NONE.
- rdata outputs hold their last value when rvalid=0.

## Timing
- Handshake in cycle N → mem_en/we/addr/wdata registered, visible cycle N+1.
- Read data: mem_rdata valid cycle N+1+RD_LAT; *_rvalid/*_rdata registered, visible cycle N+2+RD_LAT.
- Throughput 1 access/cycle. Back-to-back reads from both requesters return in issue order.
- Reset values (all outputs): 0, except mem_en=1, mem_we=1, mem_addr=0 from the first clock after reset deassertion (clear write 0).
- Reset mid-operation: tag pipeline flushed, no rvalid for in-flight reads, clear restarts at address 0.
- Host starvation bound without scan_urgent: host granted within MAX_WAIT+1 cycles of a continuous request.
- DEPTH=1: CLEAR lasts exactly one cycle.

## Structure
- Shared package fb_pkg:
  - typedef fb_tag_t {TAG_NONE, TAG_SCAN, TAG_HOST}
  - typedef fb_arb_state_t {CLEAR, NORMAL, BOOST}
  - default ADDR_W/DATA_W constants shared with the scan-out prefetcher.
- One sub-module: fb_rd_tag_pipe, an RD_LAT+1-deep tag shift register with async clear. It outputs the tag aligned with mem_rdata.

## Test plan
- Reset, DEPTH=16: writes to addrs 0..15 with data 0 on cycles 1..16, init_done high at cycle 16, no grants before it.
- Scan and host both requesting every cycle, MAX_WAIT=8: scan granted 8 cycles, host granted the 9th, pattern repeats; mem_addr sequence matches.
- Same as previous, with scan_urgent=1 throughout: host never granted, wait_cnt holds 8, state stays BOOST.
- Host writes 0x1234 to 0x00100, then scan reads 0x00100: scan_rvalid at grant+2+RD_LAT with scan_rdata=0x1234, host_rvalid never pulses.
- Interleaved scan read A and host read B on consecutive cycles: scan_rvalid then host_rvalid on consecutive cycles, with the correct data each.
- Reset asserted with 2 reads in flight: no rvalid after reset, clear restarts at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Framebuffer shared types and default widths, common to the port arbiter
// and the scan-out prefetcher.
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_SCAN,
        TAG_HOST
    } fb_tag_t;

    typedef enum logic [1:0] {
        CLEAR,
        NORMAL,
        BOOST
    } fb_arb_state_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester and RAM-side signals of the framebuffer port arbiter.
// slave = the arbiter, master = requesters plus RAM.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = fb_pkg::FB_ADDR_W,
    parameter int DATA_W = fb_pkg::FB_DATA_W
);

    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_urgent;
    logic              scan_gnt;
    logic              scan_rvalid;
    logic [DATA_W-1:0] scan_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  scan_req, scan_addr, scan_urgent,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output scan_gnt, scan_rvalid, scan_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output scan_req, scan_addr, scan_urgent,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  scan_gnt, scan_rvalid, scan_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Read-owner tag delay line; tag_out lines up with the RAM read data.
// Latency: STAGES cycles from tag_in to tag_out.
// Backpressure: none, shifts every cycle; async clear drops in-flight tags.
module fb_rd_tag_pipe
    import fb_pkg::*;
#(
    parameter int STAGES = 3
) (
    input  logic    CLK_SYS,
    input  logic    Reset_Button,
    input  fb_tag_t tag_in,
    output fb_tag_t tag_out
);

    fb_tag_t stage_q [STAGES];
    fb_tag_t stage_d [STAGES];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge CLK_SYS or negedge Reset_Button) begin
        if (!Reset_Button) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[STAGES-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: zero-fill after reset, then scan-priority with host boost.
// Latency: command registered 1 cycle after grant; read data returned RD_LAT+2 cycles after grant.
// Backpressure: combinational grants; requesters hold req and payload until their grant.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic             CLK_SYS,
    input  logic             Reset_Button,
    fb_port_arbiter_if.slave bus,
    output logic             init_done
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

    fb_arb_state_t     state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              scan_rvalid_q, scan_rvalid_d;
    logic [DATA_W-1:0] scan_rdata_q, scan_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic    scan_gnt;
    logic    host_gnt;
    fb_tag_t tag_in;
    fb_tag_t tag_out;

    always_comb begin
        scan_gnt = 1'b0;
        host_gnt = 1'b0;
        unique case (state_q)
            NORMAL: begin
                scan_gnt = bus.scan_req;
                host_gnt = bus.host_req && !bus.scan_req;
            end
            BOOST: begin
                // Urgent scan beats a boosted host only when scan actually has a request.
                scan_gnt = bus.scan_req && (bus.scan_urgent || !bus.host_req);
                host_gnt = bus.host_req && !scan_gnt;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_in      = TAG_NONE;

        if (!bus.host_req || host_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        unique case (state_q)
            CLEAR: begin
                // mem_addr_q doubles as the clear pointer: it holds the write now on the bus.
                if (mem_addr_q == LAST_ADDR) begin
                    state_d = NORMAL;
                end else begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + 1'b1;
                    mem_wdata_d = '0;
                    if (mem_addr_d == LAST_ADDR) begin
                        state_d = NORMAL;
                    end
                end
            end
            NORMAL: begin
                if (wait_cnt_d == WAIT_MAX) begin
                    state_d = BOOST;
                end
            end
            BOOST: begin
                if (host_gnt || !bus.host_req) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = CLEAR;
        endcase

        if (scan_gnt) begin
            mem_en_d   = 1'b1;
            mem_addr_d = bus.scan_addr;
            tag_in     = TAG_SCAN;
        end else if (host_gnt) begin
            mem_en_d    = 1'b1;
            mem_we_d    = bus.host_we;
            mem_addr_d  = bus.host_addr;
            mem_wdata_d = bus.host_wdata;
            tag_in      = bus.host_we ? TAG_NONE : TAG_HOST;
        end
    end

    always_comb begin
        scan_rvalid_d = (tag_out == TAG_SCAN);
        host_rvalid_d = (tag_out == TAG_HOST);
        scan_rdata_d  = scan_rvalid_d ? bus.mem_rdata : scan_rdata_q;
        host_rdata_d  = host_rvalid_d ? bus.mem_rdata : host_rdata_q;
    end

    always_ff @(posedge CLK_SYS or negedge Reset_Button) begin
        if (!Reset_Button) begin
            state_q       <= CLEAR;
            wait_cnt_q    <= '0;
            mem_en_q      <= 1'b1;
            mem_we_q      <= 1'b1;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            scan_rvalid_q <= 1'b0;
            scan_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            scan_rvalid_q <= scan_rvalid_d;
            scan_rdata_q  <= scan_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    fb_rd_tag_pipe #(
        .STAGES (RD_LAT + 1)
    ) u_tag_pipe (
        .CLK_SYS      (CLK_SYS),
        .Reset_Button (Reset_Button),
        .tag_in       (tag_in),
        .tag_out      (tag_out)
    );

    assign bus.scan_gnt    = scan_gnt;
    assign bus.host_gnt    = host_gnt;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.scan_rvalid = scan_rvalid_q;
    assign bus.scan_rdata  = scan_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign init_done       = (state_q != CLEAR);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: behavioural RAM, shadow memory and response scoreboard.
// Latency: n/a. Backpressure: requests held until grant.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 16;
    localparam int DEPTH    = 16;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 8;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] dat;
    } rsp_t;

    typedef struct {
        int                due;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdat;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    int   cyc = 1;
    int   n_checks = 0;
    int   n_errors = 0;

    rsp_t scan_q[$];
    rsp_t host_q[$];
    cmd_t cmd_q[$];

    bit [DATA_W-1:0] ram    [512];
    bit [DATA_W-1:0] shadow [512];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK_SYS      (clk),
        .Reset_Button (rst_n),
        .bus          (bus),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 1;

    // RAM model: read data appears RD_LAT cycles after the command is on the bus.
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) ram[bus.mem_addr[8:0]] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) rd_pipe[0] <= ram[bus.mem_addr[8:0]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (scan_q.size() != 0 && scan_q[0].due == cyc) begin
                chk("scan_rvalid", 32'(bus.scan_rvalid), 32'd1);
                chk("scan_rdata", 32'(bus.scan_rdata), 32'(scan_q[0].dat));
                void'(scan_q.pop_front());
            end else begin
                chk("scan_rvalid_idle", 32'(bus.scan_rvalid), 32'd0);
            end
            if (host_q.size() != 0 && host_q[0].due == cyc) begin
                chk("host_rvalid", 32'(bus.host_rvalid), 32'd1);
                chk("host_rdata", 32'(bus.host_rdata), 32'(host_q[0].dat));
                void'(host_q.pop_front());
            end else begin
                chk("host_rvalid_idle", 32'(bus.host_rvalid), 32'd0);
            end
            if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
                chk("mem_en", 32'(bus.mem_en), 32'd1);
                chk("mem_we", 32'(bus.mem_we), 32'(cmd_q[0].we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(cmd_q[0].addr));
                if (cmd_q[0].we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cmd_q[0].wdat));
                void'(cmd_q.pop_front());
            end else if (cyc > DEPTH) begin
                chk("mem_en_idle", 32'(bus.mem_en), 32'd0);
            end
            chk("one_gnt", 32'(bus.scan_gnt & bus.host_gnt), 32'd0);
            if (bus.scan_gnt) begin
                cmd_q.push_back('{due: cyc + 1, we: 1'b0, addr: bus.scan_addr, wdat: '0});
                scan_q.push_back('{due: cyc + 2 + RD_LAT, dat: shadow[bus.scan_addr[8:0]]});
            end else if (bus.host_gnt) begin
                cmd_q.push_back('{due: cyc + 1, we: bus.host_we, addr: bus.host_addr,
                                  wdat: bus.host_wdata});
                if (bus.host_we) shadow[bus.host_addr[8:0]] = bus.host_wdata;
                else host_q.push_back('{due: cyc + 2 + RD_LAT, dat: shadow[bus.host_addr[8:0]]});
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        scan_q.delete();
        host_q.delete();
        cmd_q.delete();
        bus.scan_req    = 1'b0;
        bus.scan_urgent = 1'b0;
        bus.host_req    = 1'b0;
        for (int i = 0; i < 512; i++) shadow[i] = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mem_en", 32'(bus.mem_en), 32'd1);
            chk("rst_mem_we", 32'(bus.mem_we), 32'd1);
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_rvalid", 32'(bus.scan_rvalid | bus.host_rvalid), 32'd0);
            chk("rst_init_done", 32'(init_done), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_clear(input bit scan_pending);
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            chk("clr_mem_en", 32'(bus.mem_en), 32'd1);
            chk("clr_mem_we", 32'(bus.mem_we), 32'd1);
            chk("clr_mem_addr", 32'(bus.mem_addr), 32'(k - 1));
            chk("clr_mem_wdata", 32'(bus.mem_wdata), 32'd0);
            chk("clr_init_done", 32'(init_done), 32'(k == DEPTH));
            chk("clr_scan_gnt", 32'(bus.scan_gnt), 32'(scan_pending && k == DEPTH));
            chk("clr_host_gnt", 32'(bus.host_gnt), 32'd0);
        end
    endtask

    initial begin
        int sc;
        int hc;
        int g;
        bus.scan_req    = 1'b0;
        bus.scan_addr   = '0;
        bus.scan_urgent = 1'b0;
        bus.host_req    = 1'b0;
        bus.host_we     = 1'b0;
        bus.host_addr   = '0;
        bus.host_wdata  = '0;

        // Reset and zero-fill, with a scan request parked until NORMAL.
        apply_reset();
        bus.scan_req  = 1'b1;
        bus.scan_addr = 17'd5;
        check_clear(1'b1);

        // Both requesters continuous: eight scan grants then one host grant.
        sc = 0;
        hc = 0;
        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            bus.scan_req   = 1'b1;
            bus.scan_addr  = 17'(sc % 16);
            bus.host_req   = 1'b1;
            bus.host_we    = 1'b1;
            bus.host_addr  = 17'(32 + hc);
            bus.host_wdata = 16'hA000 + 16'(hc);
            @(negedge clk);
            chk("t2_scan_gnt", 32'(bus.scan_gnt), 32'((i % 9) != 8));
            chk("t2_host_gnt", 32'(bus.host_gnt), 32'((i % 9) == 8));
            if (bus.scan_gnt) sc++;
            if (bus.host_gnt) hc++;
        end

        // scan_urgent throughout: host starves, counter saturates, BOOST holds.
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            bus.scan_urgent = 1'b1;
            bus.scan_req    = 1'b1;
            bus.scan_addr   = 17'(sc % 16);
            bus.host_req    = 1'b1;
            bus.host_we     = 1'b1;
            bus.host_addr   = 17'(32 + hc);
            bus.host_wdata  = 16'hA000 + 16'(hc);
            @(negedge clk);
            chk("t3_host_gnt", 32'(bus.host_gnt), 32'd0);
            chk("t3_scan_gnt", 32'(bus.scan_gnt), 32'd1);
            chk("t3_state", 32'(dut.state_q), j >= 8 ? 32'(BOOST) : 32'(NORMAL));
            if (j >= 8) chk("t3_wait_cnt", 32'(dut.wait_cnt_q), 32'(MAX_WAIT));
            if (bus.scan_gnt) sc++;
        end
        @(posedge clk);
        #1;
        bus.scan_req    = 1'b0;
        bus.scan_urgent = 1'b0;
        @(negedge clk);
        chk("t3_boost_host_gnt", 32'(bus.host_gnt), 32'd1);
        @(posedge clk);
        #1 bus.host_req = 1'b0;

        // Host write then scan read of the same word.
        @(posedge clk);
        #1;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 17'h00100;
        bus.host_wdata = 16'h1234;
        @(negedge clk);
        chk("t4_host_gnt", 32'(bus.host_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.host_req  = 1'b0;
        bus.scan_req  = 1'b1;
        bus.scan_addr = 17'h00100;
        @(negedge clk);
        chk("t4_scan_gnt", 32'(bus.scan_gnt), 32'd1);
        g = cyc;
        @(posedge clk);
        #1 bus.scan_req = 1'b0;
        while (cyc < g + 2 + RD_LAT) @(negedge clk);
        chk("t4_scan_rvalid", 32'(bus.scan_rvalid), 32'd1);
        chk("t4_scan_rdata", 32'(bus.scan_rdata), 32'h1234);
        @(negedge clk);
        chk("t4_rvalid_drop", 32'(bus.scan_rvalid), 32'd0);
        chk("t4_rdata_hold", 32'(bus.scan_rdata), 32'h1234);

        // Scan read then host read on consecutive cycles.
        @(posedge clk);
        #1;
        bus.scan_req  = 1'b1;
        bus.scan_addr = 17'h00100;
        @(negedge clk);
        chk("t5_scan_gnt", 32'(bus.scan_gnt), 32'd1);
        g = cyc;
        @(posedge clk);
        #1;
        bus.scan_req  = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 17'h00021;
        @(negedge clk);
        chk("t5_host_gnt", 32'(bus.host_gnt), 32'd1);
        @(posedge clk);
        #1 bus.host_req = 1'b0;
        while (cyc < g + 2 + RD_LAT) @(negedge clk);
        chk("t5_scan_rvalid", 32'(bus.scan_rvalid), 32'd1);
        chk("t5_scan_rdata", 32'(bus.scan_rdata), 32'h1234);
        chk("t5_host_early", 32'(bus.host_rvalid), 32'd0);
        @(negedge clk);
        chk("t5_host_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("t5_host_rdata", 32'(bus.host_rdata), 32'hA001);
        repeat (4) @(negedge clk);

        // Reset with two reads in flight: they vanish and the clear restarts.
        @(posedge clk);
        #1;
        bus.scan_req  = 1'b1;
        bus.scan_addr = 17'h00100;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.scan_req  = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 17'h00020;
        @(negedge clk);
        @(posedge clk);
        #1;
        apply_reset();
        check_clear(1'b0);
        repeat (8) @(negedge clk);

        chk("scan_q_drained", 32'(scan_q.size()), 32'd0);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
